// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. Owns the PC, issues reads to a synchronous
//   (one-cycle latency) instruction memory and buffers returned words in a
//   DEPTH-entry prefetch queue. The queue head is offered to IF/ID under a
//   valid/ready handshake. A redirect from EX flushes the queue and any
//   in-flight read, and refetches from the new PC in the same cycle.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   imem_en        out  instruction memory read request this cycle
//   imem_addr      out  byte address of the request
//   imem_rdata     in   data for the request issued the previous cycle
//   redirect_valid in   taken branch/jump: flush and refetch
//   redirect_pc    in   new PC (bits [1:0] ignored)
//   ifid_valid     out  queue head valid
//   ifid_ready     in   IF/ID accepts (low while the hazard unit stalls)
//   ifid_pc        out  PC of the queue head (0 when not valid)
//   ifid_instr     out  instruction of the queue head (NOP when not valid)

module fetch_stage #(
  parameter int                  PC_W     = 9,
  parameter int                  INSTR_W  = 32,
  parameter int                  DEPTH    = 2,
  parameter logic [PC_W-1:0]     RESET_PC = '0,
  parameter logic [INSTR_W-1:0]  NOP      = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  input  logic               ifid_ready,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Architectural state
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               infl_q, infl_d;
  logic [PC_W-1:0]    inflPc_q, inflPc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;

  // Queue payload; only meaningful where the pointers/count say so
  logic [PC_W-1:0]    qPc_q    [DEPTH];
  logic [INSTR_W-1:0] qInstr_q [DEPTH];

  logic               pop;
  logic               push;
  logic               issue;
  logic [CNT_W:0]     creditUse;
  logic [PC_W-1:0]    redirAligned;
  logic               unused_redirLsb;

  assign unused_redirLsb = ^redirect_pc[1:0];
  assign redirAligned    = {redirect_pc[PC_W-1:2], 2'b00};

  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and issue decision. The credit count includes the word still
  // in flight, so every returning word is guaranteed a free queue slot.
  // Reset forces the outputs to their idle values immediately.
  always_comb begin
    ifid_valid = 1'b0;
    ifid_pc    = '0;
    ifid_instr = NOP;
    imem_en    = 1'b0;
    imem_addr  = RESET_PC;

    ifid_valid = !reset && (count_q != '0) && !redirect_valid;
    if (ifid_valid) begin
      ifid_pc    = qPc_q[rdPtr_q];
      ifid_instr = qInstr_q[rdPtr_q];
    end

    if (!reset) begin
      imem_addr = redirect_valid ? redirAligned : pc_q;
      imem_en   = redirect_valid || (creditUse < (CNT_W + 1)'(DEPTH));
    end
  end

  assign pop       = ifid_valid && ifid_ready;
  assign push      = infl_q && !redirect_valid;
  assign issue     = imem_en;
  assign creditUse = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(infl_q) - (CNT_W + 1)'(pop);

  // Next-state: a redirect empties the queue and drops the returning word;
  // otherwise push and pop update the count independently.
  always_comb begin
    pc_d     = pc_q;
    infl_d   = 1'b0;
    inflPc_d = inflPc_q;
    count_d  = count_q;
    rdPtr_d  = rdPtr_q;
    wrPtr_d  = wrPtr_q;

    if (issue) begin
      pc_d     = imem_addr + PC_W'(4);
      infl_d   = 1'b1;
      inflPc_d = imem_addr;
    end

    if (redirect_valid) begin
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = incPtr(wrPtr_q);
      end
      if (pop) begin
        rdPtr_d = incPtr(rdPtr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      infl_q   <= 1'b0;
      inflPc_q <= '0;
      count_q  <= '0;
      rdPtr_q  <= '0;
      wrPtr_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      infl_q   <= infl_d;
      inflPc_q <= inflPc_d;
      count_q  <= count_d;
      rdPtr_q  <= rdPtr_d;
      wrPtr_q  <= wrPtr_d;
    end
  end

  // Payload storage needs no reset: entries are only read when count says
  // they hold valid data.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      qPc_q[wrPtr_q]    <= inflPc_q;
      qInstr_q[wrPtr_q] <= imem_rdata;
    end
  end

endmodule
